// File: rtl/instruction_fetch_unit.sv
// Two-byte instruction fetch: reads PC and PC+1 from byte memory and writes them
// little-endian into the IR. Optional MemRdy timeout is enabled by FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH     = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input  logic                  Clock_i,
   input  logic                  Reset_i,
   input  logic                  FetchStart_i,
   input  logic                  PCLoad_i,
   input  logic [ADDR_WIDTH-1:0] PCLoadValue_i,
   input  logic [7:0]            MemData_i,
   input  logic                  MemRdy_i,
   output logic                  MemRead_o,
   output logic [ADDR_WIDTH-1:0] MemAddr_o,
   output logic [7:0]            IRByte_o,
   output logic                  IRWrite_o,
   output logic                  IRLH_o,
   output logic [ADDR_WIDTH-1:0] PC_o,
   output logic                  FetchBusy_o,
   output logic                  FetchDone_o,
   output logic                  FetchErr_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RD_LO = 3'd1;
   localparam logic [2:0] S_WR_LO = 3'd2;
   localparam logic [2:0] S_RD_HI = 3'd3;
   localparam logic [2:0] S_WR_HI = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] pc_q, pc_d;
   logic [7:0]            ir_byte_q, ir_byte_d;
   logic                  in_rd;

   assign in_rd = (state_q == S_RD_LO) || (state_q == S_RD_HI);

`ifdef FETCH_TIMEOUT_EN
   localparam int              WCW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYCLES - 1);

   logic [ADDR_WIDTH-1:0] start_pc_q, start_pc_d;
   logic [WCW-1:0]        wait_q, wait_d;
   logic                  err_q, err_d;

   // Counter is zero in every non-read state, so it starts clean on each RD entry.
   assign wait_d = (in_rd && !MemRdy_i) ? wait_q + WCW'(1) : '0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      ir_byte_d = ir_byte_q;
`ifdef FETCH_TIMEOUT_EN
      start_pc_d = start_pc_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (PCLoad_i) begin
               pc_d = PCLoadValue_i;
            end else if (FetchStart_i) begin
`ifdef FETCH_TIMEOUT_EN
               start_pc_d = pc_q;
`endif
               state_d = S_RD_LO;
            end
         end
         S_RD_LO, S_RD_HI: begin
            if (MemRdy_i) begin
               ir_byte_d = MemData_i;
               state_d   = (state_q == S_RD_LO) ? S_WR_LO : S_WR_HI;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               pc_d    = start_pc_q;
               state_d = S_IDLE;
            end
`endif
         end
         S_WR_LO: begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_RD_HI;
         end
         S_WR_HI: begin
            pc_d    = pc_q + ADDR_WIDTH'(1);
            state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock_i) begin
      if (Reset_i) begin
         state_q   <= S_IDLE;
         pc_q      <= RESET_PC;
         ir_byte_q <= '0;
`ifdef FETCH_TIMEOUT_EN
         start_pc_q <= RESET_PC;
         wait_q     <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_byte_q <= ir_byte_d;
`ifdef FETCH_TIMEOUT_EN
         start_pc_q <= start_pc_d;
         wait_q     <= wait_d;
         err_q      <= err_d;
`endif
      end
   end

   assign MemRead_o   = in_rd;
   assign MemAddr_o   = pc_q;
   assign IRByte_o    = ir_byte_q;
   assign IRWrite_o   = (state_q == S_WR_LO) || (state_q == S_WR_HI);
   assign IRLH_o      = (state_q == S_WR_HI);
   assign PC_o        = pc_q;
   assign FetchBusy_o = (state_q != S_IDLE);
   assign FetchDone_o = (state_q == S_DONE);
`ifdef FETCH_TIMEOUT_EN
   assign FetchErr_o  = err_q;
`else
   assign FetchErr_o  = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: a transaction-level model predicts
// every IR write, completion and timeout with its cycle; a monitor checks them.
module tb_instruction_fetch_unit;

   logic       clk = 1'b0, rst = 1'b1, fstart = 1'b0, pcload = 1'b0, mrdy = 1'b0;
   logic [7:0] pcval = '0, mdata;
   logic       mread, irwr, irlh, busy, fdone, ferr;
   logic [7:0] maddr, irbyte, pc;

   instruction_fetch_unit dut (
      .Clock_i(clk), .Reset_i(rst), .FetchStart_i(fstart), .PCLoad_i(pcload),
      .PCLoadValue_i(pcval), .MemData_i(mdata), .MemRdy_i(mrdy),
      .MemRead_o(mread), .MemAddr_o(maddr), .IRByte_o(irbyte), .IRWrite_o(irwr),
      .IRLH_o(irlh), .PC_o(pc), .FetchBusy_o(busy), .FetchDone_o(fdone), .FetchErr_o(ferr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] mem [256];
   assign mdata = mem[maddr];

   // kind: 0 = IR low write, 1 = IR high write, 2 = FetchDone, 3 = FetchErr
   typedef struct {
      int         kind;
      logic [7:0] val;
      logic [7:0] pc;
      logic [15:0] ir;
      int         at_edge;
   } exp_t;

   exp_t sbq[$];
   int   waits[$];
   int   total = 0, passed = 0;
   logic [7:0]  mpc = 8'h00;
   logic [15:0] irm = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   function automatic exp_t mk(int k, logic [7:0] v, logic [7:0] p, logic [15:0] ir, int at);
      exp_t e;
      e.kind = k; e.val = v; e.pc = p; e.ir = ir; e.at_edge = at;
      return e;
   endfunction

   // Memory responder: each read phase takes the next wait count from the queue.
   initial begin
      int  rcnt;
      bit  in_read;
      rcnt = 0; in_read = 0;
      forever begin
         @(negedge clk);
         if (mread) begin
            if (!in_read) begin
               in_read = 1;
               rcnt = (waits.size() > 0) ? waits.pop_front() : 0;
            end
            if (rcnt > 0) begin mrdy = 1'b0; rcnt--; end
            else mrdy = 1'b1;
         end else begin
            in_read = 0;
            mrdy = 1'b0;
         end
      end
   end

   // Monitor: events seen at negedge belong to the following rising edge (cyc+1).
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (mread && sbq.size() > 0) chk("mem_addr", maddr, sbq[0].pc);
            if (irwr) begin
               if (sbq.size() == 0 || sbq[0].kind > 1) chk("irwrite_unexpected", irwr, 1'b0);
               else begin
                  e = sbq.pop_front();
                  chk("irlh", irlh, e.kind);
                  chk("irbyte", irbyte, e.val);
                  chk("irwrite_cycle", cyc + 1, e.at_edge);
                  chk("pc_at_irwrite", pc, e.pc);
                  if (irlh) irm[15:8] = irbyte; else irm[7:0] = irbyte;
               end
            end
            if (fdone) begin
               if (sbq.size() == 0 || sbq[0].kind != 2) chk("fetchdone_unexpected", fdone, 1'b0);
               else begin
                  e = sbq.pop_front();
                  chk("done_cycle", cyc + 1, e.at_edge);
                  chk("done_pc", pc, e.pc);
                  chk("done_ir", irm, e.ir);
               end
            end
            if (ferr) begin
               if (sbq.size() == 0 || sbq[0].kind != 3) chk("fetcherr_unexpected", ferr, 1'b0);
               else begin
                  e = sbq.pop_front();
                  chk("err_cycle", cyc + 1, e.at_edge);
                  chk("err_pc", pc, e.pc);
                  chk("err_busy", busy, 1'b0);
               end
            end
         end
      end
   end

   // All driver tasks start and end just after a rising edge.
   task automatic load_pc(input logic [7:0] v);
      pcload = 1'b1; pcval = v;
      @(posedge clk); #1;
      pcload = 1'b0;
      mpc = v;
   endtask

   task automatic start_fetch(input int w0, input int w1);
      logic [7:0] p, p1, p2;
      int n;
      p = mpc; p1 = p + 8'd1; p2 = p + 8'd2;
      n = cyc + 1;
      waits.push_back(w0);
      waits.push_back(w1);
      sbq.push_back(mk(0, mem[p],  p,  '0, n + 2 + w0));
      sbq.push_back(mk(1, mem[p1], p1, '0, n + 4 + w0 + w1));
      sbq.push_back(mk(2, '0, p2, {mem[p1], mem[p]}, n + 5 + w0 + w1));
      mpc = p2;
      fstart = 1'b1;
      @(posedge clk); #1;
      fstart = 1'b0;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while ((sbq.size() > 0 || busy) && k < 200) begin
         @(posedge clk); #1;
         k++;
      end
      if (k >= 200) chk("idle_timeout", sbq.size(), 0);
      chk("pc_after_fetch", pc, mpc);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed", passed, total);
      $fatal(1);
   end

   initial begin
      foreach (mem[i]) mem[i] = 8'($urandom);
      mem[8'h10] = 8'h34; mem[8'h11] = 8'h12;
      mem[8'hFF] = 8'hA5; mem[8'h00] = 8'h5A;

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_pc", pc, 8'h00);
      chk("rst_memread", mread, 1'b0);
      chk("rst_irwrite", irwr, 1'b0);
      chk("rst_irlh", irlh, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", fdone, 1'b0);
      chk("rst_err", ferr, 1'b0);
      chk("rst_irbyte", irbyte, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0;

      // Zero-wait fetch at 0x10
      load_pc(8'h10);
      start_fetch(0, 0);
      wait_idle();
      chk("ir_0x1234", irm, 16'h1234);

      // Three wait cycles on the low byte
      load_pc(8'h10);
      start_fetch(3, 0);
      wait_idle();

      // PC wrap from 0xFF
      load_pc(8'hFF);
      start_fetch(0, 0);
      wait_idle();
      chk("pc_wrap", pc, 8'h01);
      chk("ir_wrap", irm, 16'h5AA5);

      // Reset while waiting in the high-byte read
      load_pc(8'h40);
      start_fetch(0, 5);
      repeat (3) begin @(posedge clk); #1; end
      chk("in_rd_hi", mread, 1'b1);
      rst = 1'b1;
      sbq.delete(); waits.delete();
      mpc = 8'h00;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("abort_pc", pc, 8'h00);
      chk("abort_busy", busy, 1'b0);
      chk("abort_irwrite", irwr, 1'b0);
      chk("abort_done", fdone, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      wait_idle();

      // PCLoad and FetchStart together: load wins, no fetch
      pcload = 1'b1; pcval = 8'h55; fstart = 1'b1;
      @(posedge clk); #1;
      pcload = 1'b0; fstart = 1'b0;
      mpc = 8'h55;
      @(negedge clk);
      chk("prio_pc", pc, 8'h55);
      chk("prio_busy", busy, 1'b0);
      chk("prio_memread", mread, 1'b0);
      @(posedge clk); #1;

`ifdef FETCH_TIMEOUT_EN
      // MemRdy never arrives: timeout restores the start PC
      begin
         int n;
         load_pc(8'h20);
         n = cyc + 1;
         waits.push_back(1000);
         sbq.push_back(mk(3, '0, 8'h20, '0, n + 17));
         fstart = 1'b1;
         @(posedge clk); #1;
         fstart = 1'b0;
         wait_idle();
      end
`endif

      // Randomised fetches, with requests fired while busy that must be ignored
      repeat (40) begin
         if ($urandom_range(0, 1) == 1) load_pc(8'($urandom));
         start_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 2) == 0) begin
            pcload = 1'b1; pcval = 8'($urandom); fstart = 1'b1;
            @(posedge clk); #1;
            pcload = 1'b0; fstart = 1'b0;
         end
         wait_idle();
      end

      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
